spi_xfer_seq: RTL and testbench
===============================

Name: spi_xfer_seq

Overview:
Transfer sequencer that drives the bus-side interface of the SPI peripheral (din/cmd/wr/rd/dout/ack/irq) on behalf of a single client. For each job it:
- writes one configuration word,
- streams N bytes out, taking one byte per SPI transfer,
- reads each received byte back and presents it on a valid-only output.

It sits between a client (DMA or CPU glue) and the SPI peripheral, and replaces hand-sequenced register access.

Parameters:
TIMEOUT, 1023, cycles allowed waiting for spi_ack or spi_irq before aborting (counter width 10 bits)
CNT_W, 4, width of the byte-count field (maximum job length 2^CNT_W-1 = 15 bytes)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low (rst=0 resets)
start  input  1  one-cycle job request; sampled only in IDLE
len  input  CNT_W  byte count for the job; sampled with start; 0 is illegal
cfg  input  11  configuration word written via spi_cmd; sampled with start
tx_data  input  8  next byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  byte accepted this cycle (tx_valid & tx_ready)
rx_data  output  8  received byte
rx_valid  output  1  one-cycle strobe; rx_data is valid
busy  output  1  high whenever the state is not IDLE
done  output  1  one-cycle job-complete strobe
err  output  1  one-cycle strobe coincident with done on abort or illegal len
spi_din  output  11  data/config to the SPI peripheral
spi_cmd  output  1  config write strobe
spi_wr  output  1  data write strobe
spi_rd  output  1  data read strobe
spi_dout  input  9  SPI read data; [7:0] byte, [8] overrun flag
spi_ack  input  1  peripheral acknowledge, one cycle
spi_irq  input  1  transfer-complete level; cleared by the peripheral on a read

Behaviour:
- Reset (rst low, asynchronous): state=IDLE. All outputs 0. spi_din=0. Byte counter=0. Timeout counter=0.
- Strobe rule: spi_cmd, spi_wr and spi_rd each pulse high for exactly one cycle, and never more than one in the same cycle. spi_din holds its value from the strobe cycle until ack is received.
- States and transitions:
  - IDLE: when start=1 and len!=0, latch len and cfg, then go to CFG. When start=1 and len==0, pulse done and err on the next cycle and stay in IDLE.
  - CFG: spi_din=cfg, spi_cmd=1; go to CFG_ACK.
  - CFG_ACK: on spi_ack go to TXW.
  - TXW: tx_ready=1. On tx_valid, latch tx_data and go to WR. There is no timeout in TXW; the client may stall indefinitely.
  - WR: spi_din={3'b000,byte}, spi_wr=1; go to WR_ACK.
  - WR_ACK: on spi_ack go to XFER.
  - XFER: on spi_irq=1 go to RD.
  - RD: spi_rd=1; go to RD_ACK.
  - RD_ACK: on spi_ack, capture spi_dout[7:0] into rx_data and pulse rx_valid in the same cycle as the ack (registered output, visible the next cycle). Decrement the counter. If the counter reaches 0, go to DONE; otherwise go to TXW.
  - DONE: pulse done (err=0); go to IDLE.
  - ABORT: pulse done and err; go to IDLE.
- Timeout:
  - The counter clears on entry to CFG_ACK, WR_ACK, XFER and RD_ACK, and increments each cycle spent in those states.
  - When the count reaches TIMEOUT without the awaited event, go to ABORT. This gives an abort after exactly TIMEOUT wait cycles.
- Overrun: if spi_dout[8]=1 at the RD_ACK ack, the byte is still delivered on rx_valid, and the job ends via ABORT instead of continuing.
- start while busy is ignored. tx_valid outside TXW is ignored (tx_ready=0).
- spi_ack arriving in a state that does not wait for it is ignored. spi_irq seen before XFER is ignored; XFER samples only the level.
- Reset mid-job returns to IDLE immediately with no done strobe. A partially sent byte is discarded.
- Minimum per-byte latency is 6 cycles, TXW to the next TXW, with ack/irq each returned one cycle after the request.

Test Plan:
- Basic job: start with len=3 and cfg=11'h2A5; peripheral model acks after 1 cycle and asserts irq 8 cycles after the ack to wr, echoing bytes XOR 8'hFF. Send 8'h01, 8'h80, 8'hFF -> spi_cmd once with din=11'h2A5; three wr strobes with din=11'h001, 11'h080, 11'h0FF; rx_data sequence 8'hFE, 8'h7F, 8'h00; done=1 and err=0 exactly once; busy low the cycle after done.
- Illegal length: start with len=0 -> no spi strobes; done=1 and err=1 one cycle later; busy stays 0.
- Irq timeout: the model never raises irq after the first wr -> ABORT after 1023 cycles in XFER; done=1 and err=1; rx_valid never pulses.
- Overrun: len=2, first read returns spi_dout=9'h1_3C -> rx_data=8'h3C with rx_valid=1, then done=1 and err=1; no second wr.
- Client stall and ignored inputs: hold tx_valid=0 for 2000 cycles in TXW -> no abort, tx_ready stays 1. Pulse start mid-job -> ignored. Inject a stray spi_ack in XFER -> no state change. The job completes normally once tx_valid=1.
- Reset mid-job: drop rst during WR_ACK -> all outputs 0 asynchronously. After release, a new job with len=1 completes normally.

Source files
------------

// File: rtl/spi_xfer_seq_if.sv
// Bus-side connection between spi_xfer_seq and the SPI peripheral register port.
//
// Signals:
//   spi_din   [10:0]  data or configuration word presented to the peripheral
//   spi_cmd           configuration write strobe (one cycle)
//   spi_wr            data write strobe (one cycle)
//   spi_rd            data read strobe (one cycle)
//   spi_dout  [8:0]   read data from the peripheral; [7:0] byte, [8] overrun flag
//   spi_ack           one-cycle acknowledge of cmd/wr/rd
//   spi_irq           transfer-complete level, cleared by the peripheral on a read
//
// Modports:
//   master  the sequencer side (drives strobes and din)
//   slave   the peripheral side (drives dout, ack and irq)
interface spi_xfer_seq_if;

  logic [10:0] spi_din;
  logic        spi_cmd;
  logic        spi_wr;
  logic        spi_rd;
  logic [8:0]  spi_dout;
  logic        spi_ack;
  logic        spi_irq;

  modport master (
    output spi_din,
    output spi_cmd,
    output spi_wr,
    output spi_rd,
    input  spi_dout,
    input  spi_ack,
    input  spi_irq
  );

  modport slave (
    input  spi_din,
    input  spi_cmd,
    input  spi_wr,
    input  spi_rd,
    output spi_dout,
    output spi_ack,
    output spi_irq
  );

endinterface

// File: rtl/spi_xfer_seq.sv
// SPI transfer sequencer.
//
// Runs one job per start request on behalf of a single client: writes a configuration word to the
// SPI peripheral, then for each of len bytes takes a byte from the client, writes it, waits for
// the transfer-complete irq, reads the received byte back and presents it on rx_data/rx_valid.
// Every wait on the peripheral (ack or irq) is bounded by TIMEOUT cycles; expiry, an overrun flag
// on a read, or a zero length ends the job with done and err pulsing together.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-low reset
//   start, len, cfg       job request; len and cfg sampled with start while idle
//   tx_data/tx_valid/tx_ready  client byte stream into the sequencer
//   rx_data/rx_valid      received byte with a one-cycle valid strobe
//   busy                  high while a job is in progress
//   done, err             one-cycle completion strobe; err marks an aborted or illegal job
//   spi                   peripheral register port (master side)
module spi_xfer_seq #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [10:0]      cfg,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  spi_xfer_seq_if.master   spi
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  // Last count value that is still a legal wait cycle; the wait lasts exactly TIMEOUT cycles.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StCfg,
    StCfgAck,
    StTxw,
    StWr,
    StWrAck,
    StXfer,
    StRd,
    StRdAck,
    StDone,
    StAbort
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [10:0]      din_q, din_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             bad_len_q, bad_len_d;

  logic tmo_wait;
  logic tmo_expired;

  // States that wait on the peripheral and are guarded by the timeout counter.
  assign tmo_wait    = (state_q == StCfgAck) || (state_q == StWrAck) ||
                       (state_q == StXfer)   || (state_q == StRdAck);
  assign tmo_expired = tmo_wait && (tmo_q == TmoLast);

  // ---------------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // A zero-length request is answered by bad_len_q without leaving idle.
        if (start && (len != '0)) begin
          state_d = StCfg;
        end
      end
      StCfg: begin
        state_d = StCfgAck;
      end
      StCfgAck: begin
        if (spi.spi_ack) begin
          state_d = StTxw;
        end else if (tmo_expired) begin
          state_d = StAbort;
        end
      end
      StTxw: begin
        // The client may stall here indefinitely; no timeout.
        if (tx_valid) begin
          state_d = StWr;
        end
      end
      StWr: begin
        state_d = StWrAck;
      end
      StWrAck: begin
        if (spi.spi_ack) begin
          state_d = StXfer;
        end else if (tmo_expired) begin
          state_d = StAbort;
        end
      end
      StXfer: begin
        if (spi.spi_irq) begin
          state_d = StRd;
        end else if (tmo_expired) begin
          state_d = StAbort;
        end
      end
      StRd: begin
        state_d = StRdAck;
      end
      StRdAck: begin
        if (spi.spi_ack) begin
          // An overrun still delivers the byte but ends the job.
          if (spi.spi_dout[8]) begin
            state_d = StAbort;
          end else if (cnt_q == CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            state_d = StTxw;
          end
        end else if (tmo_expired) begin
          state_d = StAbort;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StAbort: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath: byte counter, timeout counter, write data, receive data
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    din_d      = din_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    bad_len_d  = 1'b0;

    // Any state change restarts the wait count, so each wait state starts from zero.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (tmo_wait) begin
      tmo_d = tmo_q + TmoW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            cnt_d = len;
            // The configuration word is held in din from here through its ack.
            din_d = cfg;
          end else begin
            bad_len_d = 1'b1;
          end
        end
      end
      StTxw: begin
        if (tx_valid) begin
          din_d = {3'b000, tx_data};
        end
      end
      StRdAck: begin
        if (spi.spi_ack) begin
          rx_data_d  = spi.spi_dout[7:0];
          rx_valid_d = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
        end
      end
      StAbort: begin
        cnt_d = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      tmo_q      <= '0;
      din_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bad_len_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      din_q      <= din_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      bad_len_q  <= bad_len_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    tx_ready    = 1'b0;
    spi.spi_cmd = 1'b0;
    spi.spi_wr  = 1'b0;
    spi.spi_rd  = 1'b0;
    done        = bad_len_q;
    err         = bad_len_q;

    unique case (state_q)
      StCfg:   spi.spi_cmd = 1'b1;
      StTxw:   tx_ready    = 1'b1;
      StWr:    spi.spi_wr  = 1'b1;
      StRd:    spi.spi_rd  = 1'b1;
      StDone:  done        = 1'b1;
      StAbort: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: begin
      end
    endcase

    busy        = (state_q != StIdle);
    spi.spi_din = din_q;
    rx_data     = rx_data_q;
    rx_valid    = rx_valid_q;
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq: a behavioural SPI peripheral answers every strobe with an
// ack one cycle later and raises irq a fixed delay after each write ack, echoing the written byte
// inverted. Each job's expected bus traffic, received bytes and done/err outcome are derived from
// the job description alone (length, config, bytes, overrun position, irq enabled).
module tb_spi_xfer_seq;

  localparam int unsigned TIMEOUT = 1023;
  localparam int unsigned CNT_W   = 4;
  localparam int          IRQ_DLY = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [10:0]      cfg;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  logic             err;

  spi_xfer_seq_if bus ();

  spi_xfer_seq #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .cfg      (cfg),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .spi      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral knobs
  bit irq_en   = 1'b1;
  int ovr_idx  = -1;
  bit stray_en = 1'b0;

  // Peripheral model state
  bit          ack_pend;
  bit          pend_wr;
  bit          stray_next;
  bit          holding;
  logic [10:0] hold_val;
  int          irq_timer;
  logic [7:0]  last_tx;
  int          rd_idx;
  int          hold_err;
  logic        ovr_bit;

  // Peripheral model: everything happens on the falling edge so the DUT samples stable values.
  initial begin
    bus.spi_ack  = 1'b0;
    bus.spi_irq  = 1'b0;
    bus.spi_dout = '0;
    ack_pend = 0; pend_wr = 0; stray_next = 0; holding = 0; hold_val = '0;
    irq_timer = 0; last_tx = '0; rd_idx = 0; hold_err = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.spi_ack  = 1'b0;
        bus.spi_irq  = 1'b0;
        bus.spi_dout = '0;
        ack_pend = 0; stray_next = 0; holding = 0; irq_timer = 0; rd_idx = 0;
      end else begin
        // din must stay put from the strobe until the ack has been sampled
        if (holding && (bus.spi_din !== hold_val)) hold_err++;
        if (bus.spi_ack) holding = 0;
        bus.spi_ack = 1'b0;
        if (stray_next) begin
          bus.spi_ack = 1'b1;
          stray_next  = 0;
        end
        if (irq_timer > 0) begin
          irq_timer--;
          if (irq_timer == 0) bus.spi_irq = 1'b1;
        end
        if (ack_pend) begin
          bus.spi_ack = 1'b1;
          ack_pend    = 0;
          if (pend_wr) begin
            if (irq_en) irq_timer = IRQ_DLY;
            if (stray_en) stray_next = 1;
          end
        end
        if (bus.spi_cmd || bus.spi_wr || bus.spi_rd) begin
          ack_pend = 1;
          pend_wr  = bus.spi_wr;
          holding  = 1;
          hold_val = bus.spi_din;
        end
        if (bus.spi_cmd) rd_idx = 0;
        if (bus.spi_wr) last_tx = bus.spi_din[7:0];
        if (bus.spi_rd) begin
          bus.spi_irq  = 1'b0;
          ovr_bit      = (rd_idx == ovr_idx);
          bus.spi_dout = {ovr_bit, last_tx ^ 8'hFF};
          rd_idx++;
        end
      end
    end
  end

  // Bus/client monitor
  logic [10:0] cmd_q[$];
  logic [10:0] wr_q[$];
  logic [7:0]  rx_q[$];
  int rd_cnt, done_cnt, err_cnt, multi_cnt, lone_err;

  initial begin
    rd_cnt = 0; done_cnt = 0; err_cnt = 0; multi_cnt = 0; lone_err = 0;
    forever begin
      @(negedge clk);
      if (bus.spi_cmd) cmd_q.push_back(bus.spi_din);
      if (bus.spi_wr) wr_q.push_back(bus.spi_din);
      if (bus.spi_rd) rd_cnt++;
      if ((int'(bus.spi_cmd) + int'(bus.spi_wr) + int'(bus.spi_rd)) > 1) multi_cnt++;
      if (rx_valid) rx_q.push_back(rx_data);
      if (done) begin
        done_cnt++;
        if (err) err_cnt++;
      end
      if (err && !done) lone_err++;
    end
  end

  task automatic clear_mon();
    cmd_q.delete();
    wr_q.delete();
    rx_q.delete();
    rd_cnt = 0; done_cnt = 0; err_cnt = 0; multi_cnt = 0; lone_err = 0; hold_err = 0;
  endtask

  logic [7:0] tx_bytes[16];
  bit got_done;
  int wr_k, done_k, stall_drop;

  // Drives one job as the client. With stall>0 the first byte is withheld for that many cycles of
  // tx_ready, and a second start is pulsed halfway through the stall.
  task automatic run_job(input int n, input logic [10:0] c, input int stall, input int budget);
    int idx;
    bit pend;
    int stall_left;
    bit stalling;
    bit in_stall;
    @(negedge clk);
    start = 1'b1; len = CNT_W'(n); cfg = c;
    tx_data = tx_bytes[0]; tx_valid = (stall == 0);
    @(negedge clk);
    start = 1'b0; len = '0; cfg = '0;
    idx = 0; pend = 0; stall_left = stall; stalling = (stall > 0); in_stall = 0;
    got_done = 0; wr_k = -1; done_k = -1; stall_drop = 0;
    for (int k = 0; k < budget && !got_done; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (pend) begin
        idx++;
        pend = 0;
        if (idx < n) tx_data = tx_bytes[idx];
        else tx_valid = 1'b0;
      end
      if (stalling) begin
        if (tx_ready) begin
          in_stall = 1;
          stall_left--;
          if (stall_left == stall / 2) begin
            start = 1'b1;
            len   = CNT_W'(5);
          end
          if (stall_left == 0) begin
            stalling = 0;
            tx_valid = 1'b1;
          end
        end else if (in_stall) begin
          stall_drop++;
        end
      end
      if (tx_ready && tx_valid) pend = 1;
      if (bus.spi_wr && wr_k < 0) wr_k = k;
      if (done) begin
        got_done = 1;
        done_k   = k;
      end
    end
    start = 1'b0; len = '0; tx_valid = 1'b0;
    chk("job_done_seen", 32'(got_done), 32'd1);
  endtask

  // Compares the traffic of the last job against what the job description implies.
  task automatic verify(input string tag, input int n, input logic [10:0] c, input bit irq_on,
                        input int ovr);
    int  nwr;
    int  nrx;
    bit  exp_err;
    @(negedge clk);
    chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    if (!irq_on) begin
      nwr = 1; nrx = 0; exp_err = 1;
    end else if (ovr >= 0 && ovr < n) begin
      nwr = ovr + 1; nrx = ovr + 1; exp_err = 1;
    end else begin
      nwr = n; nrx = n; exp_err = 0;
    end
    chk({tag, "_cmd_count"}, 32'(cmd_q.size()), 32'd1);
    if (cmd_q.size() > 0) chk({tag, "_cmd_din"}, 32'(cmd_q[0]), 32'(c));
    chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(nwr));
    for (int i = 0; i < nwr && i < wr_q.size(); i++)
      chk({tag, "_wr_din"}, 32'(wr_q[i]), 32'({3'b000, tx_bytes[i]}));
    chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(nrx));
    for (int i = 0; i < nrx && i < rx_q.size(); i++)
      chk({tag, "_rx_data"}, 32'(rx_q[i]), 32'(tx_bytes[i] ^ 8'hFF));
    chk({tag, "_rd_count"}, 32'(rd_cnt), 32'(nrx));
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err_count"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_one_strobe"}, 32'(multi_cnt), 32'd0);
    chk({tag, "_din_hold"}, 32'(hold_err), 32'd0);
    chk({tag, "_err_alone"}, 32'(lone_err), 32'd0);
  endtask

  int          n;
  int          ovr;
  logic [10:0] c;
  bit          seen;

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; cfg = '0; tx_data = '0; tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({tx_ready, rx_valid, busy, done, err, bus.spi_cmd, bus.spi_wr,
                           bus.spi_rd}), 32'd0);
    chk("reset_din", 32'(bus.spi_din), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic job
    clear_mon();
    irq_en = 1'b1; ovr_idx = -1;
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h80; tx_bytes[2] = 8'hFF;
    run_job(3, 11'h2A5, 0, 500);
    verify("basic", 3, 11'h2A5, 1'b1, -1);

    // Illegal length
    clear_mon();
    @(negedge clk);
    start = 1'b1; len = '0; cfg = 11'h123;
    @(negedge clk);
    start = 1'b0;
    chk("badlen_done", 32'(done), 32'd1);
    chk("badlen_err", 32'(err), 32'd1);
    chk("badlen_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("badlen_done_once", 32'(done), 32'd0);
    chk("badlen_busy_after", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("badlen_no_strobes", 32'(cmd_q.size() + wr_q.size() + rd_cnt), 32'd0);
    chk("badlen_done_count", 32'(done_cnt), 32'd1);
    chk("badlen_err_count", 32'(err_cnt), 32'd1);

    // Overrun on the first read of a two-byte job
    clear_mon();
    ovr_idx = 0;
    tx_bytes[0] = 8'hC3; tx_bytes[1] = 8'h5A;
    run_job(2, 11'h07E, 0, 500);
    verify("ovr", 2, 11'h07E, 1'b1, 0);
    ovr_idx = -1;

    // Irq never arrives: abort after exactly TIMEOUT cycles in XFER
    clear_mon();
    irq_en = 1'b0;
    tx_bytes[0] = 8'($urandom);
    c = 11'($urandom);
    run_job(1, c, 0, 1500);
    // wr cycle, ack cycle, then TIMEOUT cycles of waiting before the abort strobe
    chk("tmo_latency", 32'(done_k - wr_k), 32'(2 + TIMEOUT));
    verify("tmo", 1, c, 1'b0, -1);
    irq_en = 1'b1;

    // Client stall, start while busy, stray ack in XFER
    clear_mon();
    stray_en = 1'b1;
    tx_bytes[0] = 8'($urandom); tx_bytes[1] = 8'($urandom);
    c = 11'($urandom);
    run_job(2, c, 2000, 3000);
    stray_en = 1'b0;
    chk("stall_ready_held", 32'(stall_drop), 32'd0);
    verify("stall", 2, c, 1'b1, -1);

    // Reset in WR_ACK
    clear_mon();
    @(negedge clk);
    start = 1'b1; len = CNT_W'(3); cfg = 11'h5F0; tx_data = 8'hA7; tx_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.spi_wr) seen = 1;
    end
    chk("rst_reached_wr", 32'(seen), 32'd1);
    @(negedge clk);
    rst = 1'b0; tx_valid = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({tx_ready, rx_valid, busy, done, err, bus.spi_cmd, bus.spi_wr,
                               bus.spi_rd}), 32'd0);
    chk("rst_async_din", 32'(bus.spi_din), 32'd0);
    chk("rst_async_rx_data", 32'(rx_data), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    clear_mon();
    tx_bytes[0] = 8'($urandom);
    c = 11'($urandom);
    run_job(1, c, 0, 500);
    verify("post_rst", 1, c, 1'b1, -1);

    // Random jobs, some with an overrun somewhere in the job
    for (int j = 0; j < 6; j++) begin
      n = int'($urandom_range(1, 15));
      c = 11'($urandom);
      for (int i = 0; i < 16; i++) tx_bytes[i] = 8'($urandom);
      ovr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      ovr_idx = ovr;
      clear_mon();
      run_job(n, c, 0, 2000);
      verify("rand", n, c, 1'b1, ovr);
    end
    ovr_idx = -1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
